// File: rtl/perf_pkg.sv
// perf_pkg: shared types for the perf event collector
package perf_pkg;
  localparam int ID_W = 4;
  localparam int DATA_W = 32;
  typedef enum logic [0:0] {IDLE, DUMP} state_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
    logic last;
  } beat_t;
endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: saturating event counter where clear beats increment
module perf_counter_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clear ? '0 : (inc && !(&cnt)) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/perf_event_collector.sv
// perf_event_collector: per-event counters, cycle counter, log window and snapshot dump
module perf_event_collector import perf_pkg::*; #(
  parameter int EVENT_NUM = 16,
  parameter int CNT_WIDTH = 32,
  parameter int CYCLE_WIDTH = 64,
  parameter int IW = $clog2(EVENT_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   count_en,
  input  logic [EVENT_NUM-1:0]   event_i,
  input  logic                   clear,
  input  logic [CYCLE_WIDTH-1:0] win_start,
  input  logic [CYCLE_WIDTH-1:0] win_end,
  input  logic                   dump_req,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW-1:0]          out_id,
  output logic [CNT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [CYCLE_WIDTH-1:0] cycle_cnt,
  output logic                   log_valid
);
  logic [CNT_WIDTH-1:0] cnt [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap [EVENT_NUM];
  logic [IW-1:0] idx;
  state_t state;
  beat_t beat;
  logic last;
  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cell
    perf_counter_cell #(.W(CNT_WIDTH)) u_cell (
      .clk(clk), .rst(rst), .inc(count_en && event_i[g]), .clear(clear), .cnt(cnt[g])
    );
  end
  assign last = (state == DUMP) && (idx == IW'(EVENT_NUM - 1));
  assign beat = '{id: ID_W'(idx), data: DATA_W'(snap[idx]), last: last};
  assign out_valid = state == DUMP;
  assign busy = state == DUMP;
  assign out_id = beat.id[IW-1:0];
  assign out_data = beat.data[CNT_WIDTH-1:0];
  assign out_last = beat.last;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      cycle_cnt <= '0;
      log_valid <= 1'b0;
      for (int i = 0; i < EVENT_NUM; i++) snap[i] <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
      log_valid <= (cycle_cnt >= win_start) && (cycle_cnt < win_end);
      if (state == IDLE && dump_req) begin
        state <= DUMP;
        idx <= '0;
        for (int i = 0; i < EVENT_NUM; i++) snap[i] <= cnt[i];
      end else if (state == DUMP && out_ready) begin
        state <= last ? IDLE : DUMP;
        idx <= last ? '0 : idx + IW'(1);
      end
    end
endmodule

// File: tb/tb_perf_event_collector.sv
// tb_perf_event_collector: directed checks of counting, dump handshake, window and reset
module tb_perf_event_collector;
  logic clk = 0, rst = 0, count_en = 0, clear = 0, dump_req = 0, out_ready = 0;
  logic [15:0] event_i = '0;
  logic [63:0] win_start = 64'd10, win_end = 64'd20;
  logic out_valid, out_last, busy, log_valid;
  logic [3:0] out_id;
  logic [31:0] out_data;
  logic [63:0] cycle_cnt;
  logic [1:0] s_ev = '0;
  logic s_dump = 0, s_valid, s_id, s_last, s_busy, s_log;
  logic [3:0] s_data;
  logic [7:0] s_cyc;
  logic [31:0] exp_data [16];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  perf_event_collector dut (
    .clk(clk), .rst(rst), .count_en(count_en), .event_i(event_i), .clear(clear),
    .win_start(win_start), .win_end(win_end), .dump_req(dump_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_data(out_data), .out_last(out_last),
    .busy(busy), .cycle_cnt(cycle_cnt), .log_valid(log_valid)
  );
  perf_event_collector #(.EVENT_NUM(2), .CNT_WIDTH(4), .CYCLE_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .count_en(count_en), .event_i(s_ev), .clear(clear),
    .win_start(win_start[7:0]), .win_end(win_end[7:0]), .dump_req(s_dump), .out_valid(s_valid),
    .out_ready(out_ready), .out_id(s_id), .out_data(s_data), .out_last(s_last),
    .busy(s_busy), .cycle_cnt(s_cyc), .log_valid(s_log)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int e, input int n);
    for (int k = 0; k < n; k++) begin
      event_i = 16'(1 << e);
      step();
      event_i = '0;
      step();
    end
  endtask
  task automatic do_dump();
    dump_req = 1;
    out_ready = 1;
    step();
    dump_req = 0;
    clear = 0;
    event_i = '0;
    for (int i = 0; i < 16; i++) begin
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("id", out_id, i);
      check("data", out_data, exp_data[i]);
      check("last", out_last, i == 15);
      step();
    end
    check("busy_end", busy, 0);
    check("valid_end", out_valid, 0);
  endtask
  initial begin
    int highs, got;
    logic [63:0] prev;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_log", log_valid, 0);
    check("rst_id", out_id, 0);
    check("rst_last", out_last, 0);
    step();
    rst = 1;
    prev = 0;
    highs = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      check("cycle_inc", cycle_cnt, prev + 1);
      prev = cycle_cnt;
      check("log_win", log_valid, cycle_cnt >= 11 && cycle_cnt <= 20);
      if (log_valid) highs++;
    end
    check("log_highs", highs, 10);
    count_en = 1;
    pulse(3, 5);
    foreach (exp_data[i]) exp_data[i] = 0;
    exp_data[3] = 5;
    do_dump();
    pulse(0, 2);
    exp_data[0] = 2;
    event_i = 16'h0009;
    clear = 1;
    do_dump();
    foreach (exp_data[i]) exp_data[i] = 0;
    do_dump();
    pulse(7, 3);
    exp_data[7] = 3;
    dump_req = 1;
    out_ready = 0;
    step();
    got = 0;
    for (int c = 0; c < 100 && got < 16; c++) begin
      out_ready = (c % 3 == 0);
      dump_req = (got < 15);
      check("stall_valid", out_valid, 1);
      check("stall_id", out_id, got);
      check("stall_data", out_data, exp_data[got]);
      check("stall_last", out_last, got == 15);
      if (out_ready) got++;
      step();
    end
    dump_req = 0;
    check("stall_beats", got, 16);
    check("stall_idle", busy, 0);
    step();
    check("stall_no_redump", out_valid, 0);
    pulse(5, 2);
    dump_req = 1;
    out_ready = 1;
    step();
    dump_req = 0;
    repeat (7) step();
    check("pre_rst_id", out_id, 7);
    rst = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cycle", cycle_cnt, 0);
    win_start = 64'd20;
    win_end = 64'd10;
    step();
    rst = 1;
    foreach (exp_data[i]) exp_data[i] = 0;
    do_dump();
    highs = 0;
    for (int k = 0; k < 30; k++) begin
      if (log_valid) highs++;
      step();
    end
    check("rev_win_log", highs, 0);
    for (int k = 0; k < 14; k++) begin
      s_ev = 2'b01;
      step();
      s_ev = 2'b00;
      step();
    end
    s_dump = 1;
    step();
    s_dump = 0;
    check("sat_pre_data", s_data, 14);
    step();
    check("sat_pre_last", s_last, 1);
    for (int k = 0; k < 3; k++) begin
      s_ev = 2'b01;
      step();
      s_ev = 2'b00;
      step();
    end
    s_dump = 1;
    step();
    s_dump = 0;
    check("sat_valid", s_valid, 1);
    check("sat_id0", s_id, 0);
    check("sat_data", s_data, 15);
    step();
    check("sat_id1", s_id, 1);
    check("sat_other", s_data, 0);
    step();
    check("sat_busy", s_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
